// File: rtl/mste_cpu_sched.sv
// mste_cpu_sched: Mega STE CPU speed / cache sequencer.
//
// Turns the configuration register requests (req_16mhz, req_cache) into an
// effective CPU speed and cache enable. It also produces the CPU clock-enable
// strobe from the 32 MHz clk, and runs the tag-RAM invalidate walk.
//
// Ports:
//   clk           32 MHz system clock, rising edge
//   reset_n       synchronous reset, active low
//   req_16mhz     requested CPU speed (1 = 16 MHz)
//   req_cache     requested cache enable
//   bus_idle      no CPU bus cycle in progress
//   flush_req     single-cycle full tag invalidate request
//   cpu_clken     CPU clock-enable pulse, one clk wide
//   speed_16      current effective speed (1 = 16 MHz)
//   cache_en      cache usable for hits and fills
//   tag_clr_we    tag RAM invalidate write strobe
//   tag_clr_addr  tag RAM line being invalidated
//   flush_busy    invalidate walk in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | out of reset; tag contents unknown, walk starts on next clk
// RUN   | tags valid; cache_en follows the effective cache request
// FLUSH | invalidate walk, one line per clk, from line 0 to the last line
module mste_cpu_sched #(
    parameter int LINE_AW = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_16mhz,
    input  logic               req_cache,
    input  logic               bus_idle,
    input  logic               flush_req,
    output logic               cpu_clken,
    output logic               speed_16,
    output logic               cache_en,
    output logic               tag_clr_we,
    output logic [LINE_AW-1:0] tag_clr_addr,
    output logic               flush_busy
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [LINE_AW-1:0] LAST_LINE = '1;

    state_t             state_q, state_d;
    logic [1:0]         ph_q, ph_d;
    logic               speed_q, speed_d;
    logic               ceff_q, ceff_d;
    logic [LINE_AW-1:0] addr_q, addr_d;
    logic               ceff;
    logic               restart;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            ph_q    <= 2'd0;
            speed_q <= 1'b0;
            ceff_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            speed_q <= speed_d;
            ceff_q  <= ceff_d;
            addr_q  <= addr_d;
        end
    end

    // ph == 3 is a strobe at both rates, so switching there never produces
    // a short or stretched CPU cycle.
    always_comb begin
        ph_d    = ph_q + 2'd1;
        speed_d = speed_q;
        if ((ph_q == 2'd3) && bus_idle && (req_16mhz != speed_q)) begin
            speed_d = req_16mhz;
        end
    end

    // The cache is only valid at 16 MHz; any loss of the effective request
    // leaves stale tags behind and forces a walk.
    always_comb begin
        ceff    = speed_q & req_cache;
        ceff_d  = ceff;
        restart = flush_req | (ceff_q & ~ceff);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            INIT: begin
                state_d = FLUSH;
                addr_d  = '0;
            end
            RUN: begin
                if (restart) begin
                    state_d = FLUSH;
                    addr_d  = '0;
                end
            end
            FLUSH: begin
                // A restart wins over completion, even on the last line.
                if (restart) begin
                    addr_d = '0;
                end else if (addr_q == LAST_LINE) begin
                    state_d = RUN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        cpu_clken    = reset_n & (speed_q ? ph_q[0] : (ph_q == 2'd3));
        speed_16     = speed_q;
        cache_en     = (state_q == RUN) & ceff;
        tag_clr_we   = (state_q == FLUSH);
        flush_busy   = (state_q == FLUSH);
        tag_clr_addr = addr_q;
    end

endmodule

// File: tb/tb_mste_cpu_sched.sv
module tb_mste_cpu_sched;

    localparam int AW    = 4;
    localparam int LINES = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_16mhz;
    logic          req_cache;
    logic          bus_idle;
    logic          flush_req;
    logic          cpu_clken;
    logic          speed_16;
    logic          cache_en;
    logic          tag_clr_we;
    logic [AW-1:0] tag_clr_addr;
    logic          flush_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    mste_cpu_sched #(.LINE_AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_16mhz    (req_16mhz),
        .req_cache    (req_cache),
        .bus_idle     (bus_idle),
        .flush_req    (flush_req),
        .cpu_clken    (cpu_clken),
        .speed_16     (speed_16),
        .cache_en     (cache_en),
        .tag_clr_we   (tag_clr_we),
        .tag_clr_addr (tag_clr_addr),
        .flush_busy   (flush_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_walk(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
    endtask

    // Monitor: every invalidate write is matched against the expected line
    // sequence; cpu_clken spacing is checked against the current speed.
    int  since     = 0;
    bit  have_last = 1'b0;
    always @(negedge clk) begin
        if (tag_clr_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tag_write", int'(tag_clr_addr), -1);
            end else begin
                chk("tag_clr_addr", int'(tag_clr_addr), exp_q.pop_front());
            end
        end
        chk("flush_busy", int'(flush_busy), int'(tag_clr_we));
        if (!reset_n) begin
            chk("clken_in_reset", int'(cpu_clken), 0);
            have_last = 1'b0;
            since     = 0;
        end else begin
            since++;
            if (cpu_clken) begin
                if (have_last) chk("clken_period", since, speed_16 ? 2 : 4);
                have_last = 1'b1;
                since     = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_16mhz = 1'b0;
        req_cache = 1'b0;
        bus_idle  = 1'b1;
        flush_req = 1'b0;
        step(3);
        chk("rst_speed", int'(speed_16), 0);
        chk("rst_cache_en", int'(cache_en), 0);
        chk("rst_we", int'(tag_clr_we), 0);
        chk("rst_busy", int'(flush_busy), 0);
        chk("rst_addr", int'(tag_clr_addr), 0);
        chk("rst_clken", int'(cpu_clken), 0);

        // Init walk
        push_walk(LINES);
        reset_n = 1'b1;
        step(1);
        chk("init_we_first", int'(tag_clr_we), 1);
        chk("init_addr_first", int'(tag_clr_addr), 0);
        step(15);
        chk("init_we_last", int'(tag_clr_we), 1);
        chk("init_addr_last", int'(tag_clr_addr), LINES - 1);
        step(1);
        chk("init_done_we", int'(tag_clr_we), 0);
        chk("init_done_cache_en", int'(cache_en), 0);

        // Switch to 16 MHz, requested at ph = 1
        req_16mhz = 1'b1;
        step(2);
        chk("sw16_before", int'(speed_16), 0);
        step(1);
        chk("sw16_after", int'(speed_16), 1);

        // Request 8 MHz while the bus is busy for 20 clk
        req_16mhz = 1'b0;
        bus_idle  = 1'b0;
        step(20);
        chk("busy_hold", int'(speed_16), 1);
        bus_idle = 1'b1;
        step(3);
        chk("idle_wait_ph3", int'(speed_16), 1);
        step(1);
        chk("sw8_after", int'(speed_16), 0);

        // Two-clk request pulse covering ph = 3 while the bus is busy
        bus_idle = 1'b0;
        step(3);
        req_16mhz = 1'b1;
        step(2);
        req_16mhz = 1'b0;
        step(1);
        bus_idle = 1'b1;
        step(8);
        chk("pulse_no_switch", int'(speed_16), 0);

        // Cache on at 16 MHz, then drop req_cache
        req_16mhz = 1'b1;
        req_cache = 1'b1;
        step(2);
        chk("cache_speed16", int'(speed_16), 1);
        chk("cache_en_on", int'(cache_en), 1);
        step(1);
        push_walk(LINES);
        req_cache = 1'b0;
        #1;
        chk("cache_drop_same_cycle", int'(cache_en), 0);
        chk("cache_drop_no_we_yet", int'(tag_clr_we), 0);
        step(1);
        chk("drop_walk_we", int'(tag_clr_we), 1);
        chk("drop_walk_addr0", int'(tag_clr_addr), 0);
        step(15);
        chk("drop_walk_addr_last", int'(tag_clr_addr), LINES - 1);
        step(1);
        chk("drop_walk_done", int'(tag_clr_we), 0);

        // Cache on, then drop speed with a flush_req in the fall cycle
        req_cache = 1'b1;
        #1;
        chk("cache_en_again", int'(cache_en), 1);
        step(1);
        req_16mhz = 1'b0;
        step(1);
        chk("speed_fall", int'(speed_16), 0);
        chk("cache_en_speed_fall", int'(cache_en), 0);
        push_walk(LINES);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        chk("combo_walk_we", int'(tag_clr_we), 1);
        chk("combo_walk_addr0", int'(tag_clr_addr), 0);
        step(16);
        chk("combo_walk_done", int'(tag_clr_we), 0);

        // flush_req at line 9 restarts the walk
        push_walk(10);
        push_walk(LINES);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        step(9);
        chk("mid_addr9", int'(tag_clr_addr), 9);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        chk("restart_addr0", int'(tag_clr_addr), 0);
        chk("restart_we", int'(tag_clr_we), 1);
        step(15);
        chk("restart_still_busy", int'(flush_busy), 1);
        step(1);
        chk("restart_done", int'(flush_busy), 0);

        // Reset in the middle of a walk
        push_walk(5);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        step(4);
        chk("pre_reset_addr4", int'(tag_clr_addr), 4);
        reset_n = 1'b0;
        step(2);
        chk("reset_mid_we", int'(tag_clr_we), 0);
        chk("reset_mid_addr", int'(tag_clr_addr), 0);
        push_walk(LINES);
        reset_n = 1'b1;
        step(1);
        chk("rewalk_we", int'(tag_clr_we), 1);
        step(15);
        chk("rewalk_addr_last", int'(tag_clr_addr), LINES - 1);
        step(1);
        chk("rewalk_done", int'(tag_clr_we), 0);

        // flush_req on the last line never shortens the walk
        push_walk(LINES);
        push_walk(LINES);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        step(15);
        chk("last_line_addr", int'(tag_clr_addr), LINES - 1);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        chk("last_line_restart_we", int'(tag_clr_we), 1);
        chk("last_line_restart_addr", int'(tag_clr_addr), 0);
        step(16);
        chk("last_line_done", int'(tag_clr_we), 0);

        step(8);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
